// File: rtl/uart_frame_ctrl_pkg.sv
// uart_frame_ctrl_pkg
// Shared definitions for the UART command-frame controller:
//   - state_t    : frame-assembly FSM states
//   - ERR_*      : error codes reported on o_err_code
//   - CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   - TMO_CNT_W  : width of the inter-byte timeout counter
//   - sum8_step  : one step of the default additive check
// Optional feature macro used by the importing files: UART_FRAME_CRC8_EN
package uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Large enough for the biggest supported timeout (2^20-1 clocks).
  localparam int TMO_CNT_W = 20;

  // Running additive check: the sum wraps naturally at 8 bits.
  function automatic logic [7:0] sum8_step(input logic [7:0] acc,
                                           input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_crc8_step.sv
// crc8_step
// One byte of a CRC-8 update (MSB first, no reflection, no final XOR).
// Purely combinational; used only when UART_FRAME_CRC8_EN is defined.
// Ports:
//   i_crc_in  [7:0]  CRC accumulated over the previous bytes
//   i_byte    [7:0]  next message byte
//   o_crc_out [7:0]  CRC including i_byte
module crc8_step
  import uart_frame_ctrl_pkg::*;
(
  input  logic [7:0] i_crc_in,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc_out
);

  logic [7:0] w_crc;

  // Fold the byte into the register, then shift out eight bits, reducing by
  // the polynomial whenever a one falls off the top.
  always_comb begin
    w_crc = i_crc_in ^ i_byte;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[7]) begin
        w_crc = {w_crc[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        w_crc = {w_crc[6:0], 1'b0};
      end
    end
  end

  assign o_crc_out = w_crc;

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Assembles 5-byte command frames (sync, addr, data hi, data lo, check) from
// a UART byte stream and issues single-cycle 16-bit register writes. Bad
// checks, out-of-range addresses and inter-byte timeouts drop the frame and
// pulse o_err with a held cause in o_err_code.
// Build option: define UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07) as the
// check byte; otherwise the check is addr+hi+lo mod 256.
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_rx_data[7:0] received byte, valid with i_rx_valid
//   i_rx_valid    one-cycle byte strobe
//   o_wr_en       one-cycle register write strobe
//   o_wr_addr[7:0]  write address, held until the next write
//   o_wr_data[15:0] write data {hi,lo}, held until the next write
//   o_busy        frame in progress
//   o_err         one-cycle frame error strobe
//   o_err_code[1:0] cause of the last error, held until the next error
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         NUM_REGS    = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST   = TMO_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]           ADDR_LIMIT = 9'(NUM_REGS);

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_addr;
  logic [7:0]            r_hi;
  logic [7:0]            r_lo;
  logic [7:0]            r_chk;
  logic [7:0]            w_chk_next;
  logic [TMO_CNT_W-1:0]  r_tmo_cnt;
  logic                  w_expired;
  logic                  w_do_write;
  logic                  w_do_err;
  logic [1:0]            w_err_code;
  logic                  r_wr_en;
  logic [7:0]            r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_err;
  logic [1:0]            r_err_code;

  assign w_expired = (r_tmo_cnt == TMO_LAST);

  // The check is accumulated byte by byte as addr/hi/lo arrive, so the
  // check byte only needs a single compare.
`ifdef UART_FRAME_CRC8_EN
  crc8_step u_crc8_step (
    .i_crc_in  (r_chk),
    .i_byte    (i_rx_data),
    .o_crc_out (w_chk_next)
  );
`else
  assign w_chk_next = sum8_step(r_chk, i_rx_data);
`endif

  // Next-state and frame-outcome decode. A byte arriving on the expiry cycle
  // takes precedence over the timeout, so the timeout only applies when no
  // byte is present.
  always_comb begin
    w_next_state = r_state;
    w_do_write   = 1'b0;
    w_do_err     = 1'b0;
    w_err_code   = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          w_next_state = ST_ADDR;
        end
      end
      ST_ADDR: if (i_rx_valid) w_next_state = ST_DHI;
      ST_DHI:  if (i_rx_valid) w_next_state = ST_DLO;
      ST_DLO:  if (i_rx_valid) w_next_state = ST_CHK;
      ST_CHK: begin
        if (i_rx_valid) begin
          w_next_state = ST_IDLE;
          if (i_rx_data != r_chk) begin
            w_do_err   = 1'b1;
            w_err_code = ERR_CHK;
          end else if ({1'b0, r_addr} >= ADDR_LIMIT) begin
            w_do_err   = 1'b1;
            w_err_code = ERR_ADDR;
          end else begin
            w_do_write = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && !i_rx_valid && w_expired) begin
      w_next_state = ST_IDLE;
      w_do_err     = 1'b1;
      w_err_code   = ERR_TMO;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Inter-byte timeout counter: cleared by every accepted byte and held at
  // zero whenever the controller is (or is about to be) idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (i_rx_valid || (w_next_state == ST_IDLE)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Frame field capture and running check. The check restarts from zero
  // while idle so each frame starts from a clean accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_chk  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_chk <= '0;
    end else if (i_rx_valid) begin
      case (r_state)
        ST_ADDR: begin
          r_addr <= i_rx_data;
          r_chk  <= w_chk_next;
        end
        ST_DHI: begin
          r_hi  <= i_rx_data;
          r_chk <= w_chk_next;
        end
        ST_DLO: begin
          r_lo  <= i_rx_data;
          r_chk <= w_chk_next;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: strobes last one clock, address/data and error code
  // hold their last values until the next write or error respectively.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_wr_en <= w_do_write;
      r_err   <= w_do_err;
      if (w_do_write) begin
        r_wr_addr <= r_addr;
        r_wr_data <= {r_hi, r_lo};
      end
      if (w_do_err) begin
        r_err_code <= w_err_code;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl
// Scoreboard bench for uart_frame_ctrl. A frame-level reference model turns
// every driven cycle into expected write/error events (with the cycle they
// must appear on); an independent monitor pops and compares them whenever
// the DUT pulses o_wr_en or o_err. Works in either check build
// (UART_FRAME_CRC8_EN defined or not).
module tb_uart_frame_ctrl;

  localparam logic [7:0] SYNC  = 8'hAA;
  localparam int         NREGS = 16;
  localparam int         TMO   = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic [15:0] wrData;
  logic        busy;
  logic        err;
  logic [1:0]  errCode;

  uart_frame_ctrl #(
    .SYNC_BYTE   (SYNC),
    .NUM_REGS    (NREGS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rxData),
    .i_rx_valid (rxValid),
    .o_wr_en    (wrEn),
    .o_wr_addr  (wrAddr),
    .o_wr_data  (wrData),
    .o_busy     (busy),
    .o_err      (err),
    .o_err_code (errCode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          isErr;
    logic [1:0]  code;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  heldCode;
    int          cycle;
  } evt_t;

  evt_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: frame bytes seen after sync, idle cycles since
  // the last accepted byte, and the values the held outputs should show.
  bit          mInFrame  = 0;
  logic [7:0]  mBytes[$];
  int          mGap      = 0;
  logic [7:0]  mLastAddr = 8'h00;
  logic [15:0] mLastData = 16'h0000;
  logic [1:0]  mLastCode = 2'd0;
  bit          busyExp   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Expected check byte. The CRC is computed as the remainder of the
  // 24-bit message times x^8 divided by x^8+x^2+x+1 (long division).
  function automatic logic [7:0] refCheck(input logic [7:0] a,
                                          input logic [7:0] h,
                                          input logic [7:0] l);
`ifdef UART_FRAME_CRC8_EN
    logic [31:0] m;
    m = {a, h, l, 8'h00};
    for (int i = 31; i >= 8; i--) begin
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    end
    return m[7:0];
`else
    int s;
    s = (int'(a) + int'(h) + int'(l)) % 256;
    return 8'(s);
`endif
  endfunction

  task automatic pushErr(input logic [1:0] code);
    evt_t e;
    e.isErr = 1; e.code = code; e.addr = mLastAddr; e.data = mLastData;
    e.heldCode = code; e.cycle = cyc + 1;
    expQ.push_back(e);
    mLastCode = code;
  endtask

  task automatic pushWrite(input logic [7:0] a, input logic [15:0] d);
    evt_t e;
    e.isErr = 0; e.code = 2'd0; e.addr = a; e.data = d;
    e.heldCode = mLastCode; e.cycle = cyc + 1;
    expQ.push_back(e);
    mLastAddr = a;
    mLastData = d;
  endtask

  task automatic modelStep(input bit v, input logic [7:0] b);
    if (!mInFrame) begin
      if (v && b == SYNC) begin
        mInFrame = 1;
        mBytes.delete();
        mGap = 0;
      end
    end else if (v) begin
      mBytes.push_back(b);
      mGap = 0;
      if (mBytes.size() == 4) begin
        mInFrame = 0;
        if (mBytes[3] != refCheck(mBytes[0], mBytes[1], mBytes[2]))
          pushErr(2'd1);
        else if (int'(mBytes[0]) >= NREGS)
          pushErr(2'd2);
        else
          pushWrite(mBytes[0], {mBytes[1], mBytes[2]});
      end
    end else begin
      mGap++;
      if (mGap == TMO) begin
        mInFrame = 0;
        pushErr(2'd3);
      end
    end
    busyExp = mInFrame;
  endtask

  // Drive one clock cycle of input and advance the model by that cycle.
  task automatic applyStimulus(input bit v, input logic [7:0] b);
    @(negedge clk);
    rxValid = v;
    rxData  = v ? b : 8'($urandom);
    modelStep(v, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00);
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4);
    applyStimulus(1, b0);
    applyStimulus(1, b1);
    applyStimulus(1, b2);
    applyStimulus(1, b3);
    applyStimulus(1, b4);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wr_en"},    wrEn,    0);
    checkOutput({tag, "_wr_addr"},  wrAddr,  0);
    checkOutput({tag, "_wr_data"},  wrData,  0);
    checkOutput({tag, "_busy"},     busy,    0);
    checkOutput({tag, "_err"},      err,     0);
    checkOutput({tag, "_err_code"}, errCode, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1;
    rxValid = 0;
    mInFrame = 0; mBytes.delete(); mGap = 0;
    mLastAddr = 0; mLastData = 0; mLastCode = 0; busyExp = 0;
    expQ.delete();
    #2;
    checkResetState("midreset");
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    evt_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      checkOutput("busy", busy, busyExp);
      if (wrEn || err) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse: got wr_en=%0b err=%0b code=%0d, expected no pulse (cycle %0d)",
                   wrEn, err, errCode, cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("evt_cycle", cyc, e.cycle);
          checkOutput("wr_en", wrEn, !e.isErr);
          checkOutput("err", err, e.isErr);
          checkOutput("wr_addr", wrAddr, e.addr);
          checkOutput("wr_data", wrData, e.data);
          checkOutput(e.isErr ? "err_code" : "err_code_held", errCode, e.heldCode);
        end
      end else if (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
        e = expQ.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL missed_pulse: got no pulse, expected %s code=%0d addr=0x%0h (cycle %0d)",
                 e.isErr ? "err" : "wr_en", e.code, e.addr, cyc);
      end
    end
  end

  initial begin
    logic [7:0] junk, a, h, l, c;
    int gap;
    rst = 1; rxValid = 0; rxData = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 0;
    idle(2);

    // Directed frames.
    sendFrame(8'hAA, 8'h01, 8'h12, 8'h34, 8'h47); idle(3);
    sendFrame(8'hAA, 8'h01, 8'h12, 8'h34, 8'h48); idle(3);
    sendFrame(8'hAA, 8'h10, 8'h00, 8'h00, 8'h10); idle(2);
    applyStimulus(1, 8'h55);
    sendFrame(8'hAA, 8'h0F, 8'h00, 8'h01, 8'h10); idle(3);
    // Inter-byte timeout, then a byte landing exactly on the expiry cycle.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01); idle(TMO + 3);
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01); idle(TMO - 1);
    applyStimulus(1, 8'h12); applyStimulus(1, 8'h34); applyStimulus(1, 8'h47);
    idle(3);
    // CRC-oriented vectors; the model decides the outcome for either build.
    sendFrame(8'hAA, 8'h01, 8'h00, 8'h00, 8'h6B); idle(2);
    sendFrame(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01); idle(2);
    // Sync value as a data byte must not resync.
    sendFrame(8'hAA, 8'h02, 8'hAA, 8'hAA, refCheck(8'h02, 8'hAA, 8'hAA)); idle(2);
    // Reset mid-frame, then one clean frame.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01); applyStimulus(1, 8'h12);
    doReset();
    idle(1);
    sendFrame(8'hAA, 8'h05, 8'hBE, 8'hEF, refCheck(8'h05, 8'hBE, 8'hEF));
    idle(3);

    // Randomised frames with junk, corruption, gaps and timeouts.
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h55;
        applyStimulus(1, junk);
      end
      a = 8'($urandom_range(0, 20));
      h = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
      l = 8'($urandom);
      c = refCheck(a, h, l);
      if ($urandom_range(0, 5) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      applyStimulus(1, SYNC);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 19))
          0:       gap = TMO - 1;
          1:       gap = TMO;
          default: gap = $urandom_range(0, 2);
        endcase
        idle(gap);
        applyStimulus(1, (k == 0) ? a : (k == 1) ? h : (k == 2) ? l : c);
      end
      idle($urandom_range(0, 3));
    end

    idle(TMO + 5);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
